// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared coherence types for the dual-core MSI system
package cpu_types_pkg;
  typedef enum logic [1:0] {MSI_I = 2'd0, MSI_S = 2'd1, MSI_M = 2'd2} msi_t;
  typedef enum logic [1:0] {CC_RD = 2'd0, CC_RDX = 2'd1, CC_WB = 2'd2} ccreq_t;
endpackage

// File: rtl/coherence_agent.sv
// coherence_agent: per-core MSI bus agent issuing dcache requests and answering snoops
module coherence_agent
  import cpu_types_pkg::*;
#(
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        req_done,
  output logic [31:0] resp_data,
  output logic [31:0] snp_addr,
  input  logic        snp_hit,
  input  logic [1:0]  snp_state,
  input  logic [31:0] snp_data,
  output logic        snp_upd,
  output logic [1:0]  snp_newstate,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        cctrans,
  output logic        ccwrite
);
  typedef enum logic [2:0] {IDLE, REQ, DONE, SNP_LOOK, SNP_WB, SNP_UPD} state_t;
  state_t      state_q, state_d, ret_q, ret_d;
  ccreq_t      req_type_q, req_type_d;
  msi_t        newstate_q, newstate_d;
  logic [31:0] req_addr_q, req_addr_d, req_data_q, req_data_d;
  logic [31:0] resp_data_q, resp_data_d, snp_addr_q, snp_addr_d;
  logic        snooped_q, snooped_d, ccinv_q, ccinv_d, upd_q, upd_d;
  logic        snp_go;
  assign resp_data = resp_data_q;
  assign snp_addr  = snp_addr_q;
  // state register plus request and snoop latches; reset aborts anything in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      req_type_q  <= CC_RD;
      newstate_q  <= MSI_I;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      resp_data_q <= '0;
      snp_addr_q  <= '0;
      snooped_q   <= 1'b0;
      ccinv_q     <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      req_type_q  <= req_type_d;
      newstate_q  <= newstate_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      resp_data_q <= resp_data_d;
      snp_addr_q  <= snp_addr_d;
      snooped_q   <= snooped_d;
      ccinv_q     <= ccinv_d;
      upd_q       <= upd_d;
    end
  end
  // next-state and outputs; one snoop per ccwait episode, preempting idle or an open request
  always_comb begin
    snp_go       = ccwait && !snooped_q && (state_q == IDLE || state_q == REQ);
    state_d      = state_q;
    ret_d        = ret_q;
    req_type_d   = req_type_q;
    newstate_d   = newstate_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    resp_data_d  = resp_data_q;
    snp_addr_d   = snp_addr_q;
    snooped_d    = ccwait && snooped_q;
    ccinv_d      = ccinv_q;
    upd_d        = upd_q;
    req_done     = 1'b0;
    snp_upd      = 1'b0;
    snp_newstate = MSI_I;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    cctrans      = 1'b0;
    ccwrite      = 1'b0;
    if (snp_go) begin
      state_d    = SNP_LOOK;
      ret_d      = state_q;
      snooped_d  = 1'b1;
      snp_addr_d = ccsnoopaddr;
    end
    case (state_q)
      IDLE: begin
        if (req_valid && !ccwait) begin
          state_d    = REQ;
          req_type_d = ccreq_t'(req_type);
          req_addr_d = req_addr;
          req_data_d = req_data;
        end
      end
      REQ: begin
        daddr   = req_addr_q;
        dREN    = req_type_q != CC_WB;
        dWEN    = req_type_q == CC_WB;
        ccwrite = req_type_q == CC_RDX;
        dstore  = req_type_q == CC_WB ? req_data_q : '0;
        if (!snp_go && !dwait) begin
          state_d     = DONE;
          resp_data_d = dload;
        end
      end
      DONE: begin
        req_done = 1'b1;
        cctrans  = 1'b1;
        state_d  = IDLE;
      end
      SNP_LOOK: begin
        cctrans    = 1'b1;
        ccinv_d    = ccinv;
        newstate_d = MSI_I;
        state_d    = snp_hit && snp_state == MSI_M ? SNP_WB : SNP_UPD;
        upd_d      = snp_hit && snp_state == MSI_S && ccinv;
      end
      SNP_WB: begin
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = snp_addr_q;
        dstore  = snp_data;
        if (!dwait) begin
          state_d    = SNP_UPD;
          upd_d      = 1'b1;
          newstate_d = ccinv_q ? MSI_I : MSI_S;
        end
      end
      SNP_UPD: begin
        snp_upd      = upd_q;
        snp_newstate = upd_q ? newstate_q : MSI_I;
        state_d      = ret_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
